// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling, glitch rejection and framing-error pulse.
// Returns to IDLE at mid stop bit so a back-to-back start edge is never missed.
module uart_rx #(
  parameter int unsigned DIV = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_q;
  logic          sync1_q;
  logic          rx_s_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_inc_d;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          ferr_q;

  // Saturating increment keeps the counter inside 0..DIV-1.
  always_comb begin
    cnt_inc_d = cnt_q;
    if (cnt_q != FULL_M1) begin
      cnt_inc_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx;
      rx_s_q  <= sync1_q;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!rx_s_q) begin
            state_q <= START;
          end
        end
        START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q <= '0;
            if (!rx_s_q) begin
              state_q <= DATA;
              idx_q   <= 3'd0;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        DATA: begin
          if (cnt_q == FULL_M1) begin
            shift_q[idx_q] <= rx_s_q;
            cnt_q          <= '0;
            idx_q          <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              state_q <= STOP;
            end
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            if (rx_s_q) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              ferr_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx at DIV=16.
// Expected pulses are queued with their arrival cycle; a negedge monitor pops and compares.
module tb_uart_rx;

  localparam int DIV   = 16;
  localparam int FRAME = 10 * DIV;
  localparam int LAT   = 155;

  typedef struct packed {
    logic        kind;
    logic [7:0]  d;
    logic [31:0] cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] cyc = 0;
  logic [7:0]  last_good = 8'h00;
  exp_t        sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(.DIV(DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  task automatic expect_pulse(input logic kind, input logic [7:0] d, input int offset);
    exp_t e;
    e.kind = kind;
    e.d    = d;
    e.cyc  = cyc + 32'(offset);
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (valid || frame_err) begin
      if (valid && frame_err) begin
        flag("valid and frame_err together");
      end else if (sb.size() == 0) begin
        flag(valid ? "unexpected valid" : "unexpected frame_err");
      end else begin
        e = sb.pop_front();
        check("pulse kind (1=frame_err)", {31'd0, frame_err}, {31'd0, e.kind});
        check("pulse data", {24'd0, data}, {24'd0, e.d});
        check("pulse cycle", cyc, e.cyc);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic chk_busy);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      if (k == 0) begin
        if (stop) begin
          expect_pulse(1'b0, b, LAT);
          last_good = b;
        end else begin
          expect_pulse(1'b1, last_good, LAT);
        end
      end
      if (chk_busy && k >= 3 && k <= 154 && busy !== 1'b1) bad = 1'b1;
      if (k < DIV)             rx = 1'b0;
      else if (k < 9 * DIV)    rx = b[k / DIV - 1];
      else                     rx = stop;
    end
    if (chk_busy) check("busy held through frame", {31'd0, bad}, 32'd0);
  endtask

  initial begin
    logic [7:0] b55;
    b55 = 8'h55;

    repeat (4) @(negedge clk);
    check("reset data", {24'd0, data}, 32'h00);
    check("reset valid", {31'd0, valid}, 32'd0);
    check("reset frame_err", {31'd0, frame_err}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    idle(20);

    send_frame(8'hA5, 1'b1, 1'b1);
    idle(32);

    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      rx = 1'b0;
      if (k == 4) check("busy during glitch", {31'd0, busy}, 32'd1);
    end
    idle(30);
    check("busy after glitch", {31'd0, busy}, 32'd0);
    check("data after glitch", {24'd0, data}, {24'd0, last_good});

    send_frame(8'h3C, 1'b0, 1'b0);
    idle(32);
    check("data after frame error", {24'd0, data}, 32'hA5);

    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h81, 1'b1, 1'b0);
    idle(32);

    for (int k = 0; k < 5 * DIV + 8; k++) begin
      @(negedge clk);
      if (k < DIV) rx = 1'b0;
      else         rx = b55[k / DIV - 1];
    end
    @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("busy after mid-frame reset", {31'd0, busy}, 32'd0);
    check("data after mid-frame reset", {24'd0, data}, 32'h00);
    last_good = 8'h00;
    idle(48);
    send_frame(8'h12, 1'b1, 1'b0);
    idle(32);

    for (int k = 0; k < 29 * DIV; k++) begin
      @(negedge clk);
      if (k == 0) begin
        expect_pulse(1'b1, last_good, 155);
        expect_pulse(1'b1, last_good, 308);
        expect_pulse(1'b1, last_good, 461);
      end
      rx = 1'b0;
    end
    idle(64);
    check("busy after break", {31'd0, busy}, 32'd0);
    send_frame(8'h7E, 1'b1, 1'b0);
    idle(40);

    check("scoreboard drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
